// File: rtl/cmnd_pitch_detector_pkg.sv
// Shared constants and state encoding for the CMND pitch detector slice.
// TAU_BITS_DEF must match the tau counter width of diff_module.
package cmnd_pitch_detector_pkg;

   localparam int unsigned DATA_WIDTH_DEF   = 24;
   localparam int unsigned TAU_BITS_DEF     = 9;
   localparam int unsigned TAU_MIN_DEF      = 2;
   localparam int unsigned THRESH_NUM_DEF   = 26;
   localparam int unsigned THRESH_SHIFT_DEF = 8;
   localparam int unsigned THRESH_NUM_BITS  = 8;

   typedef enum logic [1:0] {
      CMND_IDLE    = 2'd0,
      CMND_SEARCH  = 2'd1,
      CMND_DESCEND = 2'd2,
      CMND_DONE    = 2'd3
   } cmnd_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cmnd_pitch_detector_if.sv
// Sample input and pitch result signals between diff_module side and detector.
interface cmnd_pitch_detector_if
   import cmnd_pitch_detector_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned TAU_BITS   = TAU_BITS_DEF
);

   logic                  start;
   logic                  diff_valid;
   logic [DATA_WIDTH-1:0] diff_value;
   logic                  busy;
   logic                  pitch_valid;
   logic                  pitch_found;
   logic [TAU_BITS-1:0]   pitch_tau;

   modport master (
      output start, diff_valid, diff_value,
      input  busy, pitch_valid, pitch_found, pitch_tau
   );

   modport slave (
      input  start, diff_valid, diff_value,
      output busy, pitch_valid, pitch_found, pitch_tau
   );

endinterface

// File: rtl/cmnd_pitch_detector_compare.sv
// Division-free CMND threshold test: d*tau << SHIFT < NUM * running sum.
// Kept separate so the two multipliers map cleanly onto DSP blocks.
module cmnd_pitch_detector_compare
   import cmnd_pitch_detector_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int unsigned TAU_BITS     = TAU_BITS_DEF,
   parameter int unsigned THRESH_NUM   = THRESH_NUM_DEF,
   parameter int unsigned THRESH_SHIFT = THRESH_SHIFT_DEF
) (
   input  logic [DATA_WIDTH-1:0]          d,
   input  logic [TAU_BITS-1:0]            tau,
   input  logic [DATA_WIDTH+TAU_BITS-1:0] sum,
   input  logic [DATA_WIDTH-1:0]          d_min,
   output logic [DATA_WIDTH+TAU_BITS-1:0] sum_new_c,
   output logic                           below_c,
   output logic                           less_min_c
);

   localparam int unsigned SUM_W = DATA_WIDTH + TAU_BITS;
   localparam int unsigned LHS_W = SUM_W + THRESH_SHIFT;
   localparam int unsigned RHS_W = SUM_W + THRESH_NUM_BITS;
   localparam int unsigned CMP_W = max_u(LHS_W, RHS_W);

   logic [SUM_W-1:0] d_tau;
   logic [CMP_W-1:0] lhs;
   logic [CMP_W-1:0] rhs;

   // d*tau fits in DATA_WIDTH+TAU_BITS bits, so no product bits are lost
   always_comb begin
      sum_new_c  = sum + SUM_W'(d);
      d_tau      = SUM_W'(d) * SUM_W'(tau);
      lhs        = CMP_W'(d_tau) << THRESH_SHIFT;
      rhs        = CMP_W'(THRESH_NUM_BITS'(THRESH_NUM)) * CMP_W'(sum_new_c);
      below_c    = lhs < rhs;
      less_min_c = d < d_min;
   end

endmodule

// File: rtl/cmnd_pitch_detector.sv
// YIN cumulative-mean-normalised pitch detector: threshold search, then
// local-minimum descent, one registered pitch result per frame.
module cmnd_pitch_detector
   import cmnd_pitch_detector_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int unsigned TAU_BITS     = TAU_BITS_DEF,
   parameter int unsigned TAU_MIN      = TAU_MIN_DEF,
   parameter int unsigned THRESH_NUM   = THRESH_NUM_DEF,
   parameter int unsigned THRESH_SHIFT = THRESH_SHIFT_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   cmnd_pitch_detector_if.slave   bus
);

   localparam int unsigned        SUM_W     = DATA_WIDTH + TAU_BITS;
   localparam logic [TAU_BITS-1:0] TAU_MAX_T = '1;
   localparam logic [TAU_BITS-1:0] TAU_MIN_T = TAU_BITS'(TAU_MIN);
   localparam logic [TAU_BITS-1:0] TAU_ONE   = TAU_BITS'(1);

   cmnd_state_e             state_q, state_d;
   logic [TAU_BITS-1:0]     tau_q, tau_d;
   logic [SUM_W-1:0]        sum_q, sum_d;
   logic [DATA_WIDTH-1:0]   d_min_q, d_min_d;
   logic [TAU_BITS-1:0]     tau_min_q, tau_min_d;
   logic                    busy_q, busy_d;
   logic                    pitch_valid_q, pitch_valid_d;
   logic                    pitch_found_q, pitch_found_d;
   logic [TAU_BITS-1:0]     pitch_tau_q, pitch_tau_d;

   logic [SUM_W-1:0]        sum_new_c;
   logic                    below_c;
   logic                    less_min_c;
   logic                    last_c;

   cmnd_pitch_detector_compare #(
      .DATA_WIDTH   (DATA_WIDTH),
      .TAU_BITS     (TAU_BITS),
      .THRESH_NUM   (THRESH_NUM),
      .THRESH_SHIFT (THRESH_SHIFT)
   ) u_compare (
      .d          (bus.diff_value),
      .tau        (tau_q),
      .sum        (sum_q),
      .d_min      (d_min_q),
      .sum_new_c  (sum_new_c),
      .below_c    (below_c),
      .less_min_c (less_min_c)
   );

   assign last_c = (tau_q == TAU_MAX_T);

   // Next-state and result logic; start overrides everything and drops the frame
   always_comb begin
      state_d       = state_q;
      tau_d         = tau_q;
      sum_d         = sum_q;
      d_min_d       = d_min_q;
      tau_min_d     = tau_min_q;
      pitch_valid_d = 1'b0;
      pitch_found_d = pitch_found_q;
      pitch_tau_d   = pitch_tau_q;

      if (bus.start) begin
         state_d = CMND_SEARCH;
         tau_d   = TAU_ONE;
         sum_d   = '0;
      end else begin
         case (state_q)
            CMND_IDLE: begin
               state_d = CMND_IDLE;
            end
            CMND_SEARCH: begin
               if (bus.diff_valid) begin
                  sum_d = sum_new_c;
                  tau_d = tau_q + TAU_ONE;
                  if ((tau_q >= TAU_MIN_T) && below_c) begin
                     d_min_d   = bus.diff_value;
                     tau_min_d = tau_q;
                     state_d   = CMND_DESCEND;
                     // a crossing on the final lag is its own minimum
                     if (last_c) begin
                        pitch_valid_d = 1'b1;
                        pitch_found_d = 1'b1;
                        pitch_tau_d   = tau_q;
                        state_d       = CMND_DONE;
                     end
                  end else if (last_c) begin
                     pitch_valid_d = 1'b1;
                     pitch_found_d = 1'b0;
                     pitch_tau_d   = '0;
                     state_d       = CMND_DONE;
                  end
               end
            end
            CMND_DESCEND: begin
               if (bus.diff_valid) begin
                  sum_d = sum_new_c;
                  tau_d = tau_q + TAU_ONE;
                  if (less_min_c) begin
                     d_min_d   = bus.diff_value;
                     tau_min_d = tau_q;
                     if (last_c) begin
                        pitch_valid_d = 1'b1;
                        pitch_found_d = 1'b1;
                        pitch_tau_d   = tau_q;
                        state_d       = CMND_DONE;
                     end
                  end else begin
                     pitch_valid_d = 1'b1;
                     pitch_found_d = 1'b1;
                     pitch_tau_d   = tau_min_q;
                     state_d       = CMND_DONE;
                  end
               end
            end
            CMND_DONE: begin
               state_d = CMND_IDLE;
            end
            default: begin
               state_d = CMND_IDLE;
            end
         endcase
      end

      busy_d = (state_d == CMND_SEARCH) || (state_d == CMND_DESCEND);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= CMND_IDLE;
         tau_q         <= '0;
         sum_q         <= '0;
         d_min_q       <= '1;
         tau_min_q     <= '0;
         busy_q        <= 1'b0;
         pitch_valid_q <= 1'b0;
         pitch_found_q <= 1'b0;
         pitch_tau_q   <= '0;
      end else begin
         state_q       <= state_d;
         tau_q         <= tau_d;
         sum_q         <= sum_d;
         d_min_q       <= d_min_d;
         tau_min_q     <= tau_min_d;
         busy_q        <= busy_d;
         pitch_valid_q <= pitch_valid_d;
         pitch_found_q <= pitch_found_d;
         pitch_tau_q   <= pitch_tau_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.pitch_valid = pitch_valid_q;
   assign bus.pitch_found = pitch_found_q;
   assign bus.pitch_tau   = pitch_tau_q;

endmodule

// File: doc/cmnd_pitch_detector.md
Name: cmnd_pitch_detector

Overview:
Downstream consumer of diff_module. Accepts the YIN difference value d(tau) for tau = 1..TAU_MAX, one per valid beat. Applies the cumulative-mean-normalised threshold test without division and tracks the local minimum after the first crossing. Emits one pitch-period estimate per frame: tau in samples, or unvoiced.

Parameters:
DATA_WIDTH, 24, width of d(tau) from diff_module
TAU_BITS, 9, tau counter width; TAU_MAX = 2**TAU_BITS - 1
TAU_MIN, 2, smallest tau eligible as a result
THRESH_NUM, 26, threshold numerator, 8-bit unsigned
THRESH_SHIFT, 8, threshold = THRESH_NUM / 2**THRESH_SHIFT (default ~0.10)

Ports:
clk  in  1  system clock (HFOSC domain)
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a new frame, clears accumulators
diff_valid  in  1  d(tau) present on diff_value this cycle
diff_value  in  DATA_WIDTH  unsigned d(tau); first valid after start is tau=1
busy  out  1  frame in progress (SEARCH or DESCEND)
pitch_valid  out  1  one-cycle pulse, result available
pitch_found  out  1  1 = voiced, 0 = unvoiced; valid with pitch_valid
pitch_tau  out  TAU_BITS  estimated period; 0 when unvoiced

Behaviour:
- Reset values: busy=0, pitch_valid=0, pitch_found=0, pitch_tau=0. Internal state: IDLE, tau=0, sum=0, d_min=all-ones, tau_min=0.
- States: IDLE, SEARCH, DESCEND, DONE.
- start in any state moves to SEARCH, sets tau=1 and sum=0. A diff_valid in the same cycle as start is ignored.
- Accepted sample: diff_valid=1 while in SEARCH or DESCEND. diff_valid is ignored in IDLE and DONE.
- Per accepted sample:
  - sum_new = sum + d, width DATA_WIDTH+TAU_BITS. Sum cannot overflow.
  - lhs = d * tau << THRESH_SHIFT.
  - rhs = THRESH_NUM * sum_new.
  - Both are zero-extended to a common width before comparison.
- Below-threshold condition: lhs < rhs, strict. When sum_new=0, this is false, so silence is never voiced.
- SEARCH: if tau >= TAU_MIN and the condition holds:
  - load d_min=d and tau_min=tau;
  - go to DESCEND.
- DESCEND:
  - if d < d_min, update d_min and tau_min;
  - if d >= d_min, emit a voiced result with tau_min and go to DONE. Ties end the descent.
- End of frame: the sample with tau == TAU_MAX, if no decision has been made on it.
  - In SEARCH: emit unvoiced (found=0, tau=0).
  - In DESCEND: emit voiced with the updated tau_min.
  - In both cases go to DONE.
- Emit timing: registered. pitch_valid goes high the cycle after the deciding sample's accepting edge, for exactly one cycle. pitch_found and pitch_tau hold until the next emit or reset.
- DONE: go to IDLE on the next cycle. busy=0 in IDLE and DONE.
- Throughput: one sample per cycle, no back-pressure. Samples arriving after the decision are dropped.
- Reset mid-frame: return to the reset values. No pitch_valid is emitted for the aborted frame.
- start mid-frame: abort without emitting and restart the frame.

Decomposition:
- Shared constants.vh holds:
  - TAU_BITS (equal to the diff_module tau width);
  - default THRESH_NUM / THRESH_SHIFT;
  - state encodings CMND_IDLE, CMND_SEARCH, CMND_DESCEND, CMND_DONE.
- One sub-module, cmnd_compare:
  - combinational function of d, tau and sum_new;
  - computes sum_new, lhs, rhs and the below/less-than-min flags;
  - isolates the multiplier widths for DSP inference.
- The FSM and registers stay in the top of the block.

Test Plan:
- d=100 for tau 1..9, d(10)=5, d(11)=3, d(12)=50 -> pitch_valid once, found=1, tau=11, one cycle after tau=12. At tau=10: lhs=12800, rhs=23530.
- d=100 for all tau 1..511 -> no crossing (25600*tau vs 2600*tau); pitch_valid after tau=511, found=0, tau=0.
- d=0 for all tau -> sum stays 0; unvoiced result at frame end.
- d(1)=0 then d=100 for all later tau -> tau=1 is not eligible (TAU_MIN=2); unvoiced result.
- d strictly decreasing from tau=500 to 511 after a crossing at tau=500 -> found=1, tau=511, emitted after the last sample.
- reset asserted at tau=50 of a crossing frame, then start with the test-1 data -> no pitch_valid before the restart; tau=11 afterwards.
